blk_mem_responder: RTL and testbench

Memory-side responder for the 256-bit block interface that the pipelined MIPS cache drives (iBlkRead/iBlkWrite, dBlkRead/dBlkWrite).
- Accepts one block read or block write request at a time.
- Models a fixed access latency.
- Returns or commits a 32-byte block using a 4-phase request/ready handshake.
- One instance sits behind the I-side port and one behind the D-side port in the system testbench/top.

---
 rtl/blk_if_pkg.sv | 19 +
 rtl/blk_mem_array.sv | 22 ++
 rtl/blk_mem_responder.sv | 112 +++++++++++
 tb/tb_blk_mem_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/blk_if_pkg.sv
// Shared types and widths for the 256-bit block memory interface.
package blk_if_pkg;

  localparam int BLK_W    = 256;
  localparam int WORD_W   = 32;
  localparam int OFF_BITS = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READY  = 2'd2
  } blk_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } blk_op_e;

endpackage

// File: rtl/blk_mem_array.sv
// Single-port synchronous block RAM with registered read data; contents are never reset.
module blk_mem_array
  import blk_if_pkg::*;
#(
  parameter int DEPTH_BLOCKS = 1024,
  parameter int IDX_W        = $clog2(DEPTH_BLOCKS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [BLK_W-1:0] wdata,
  output logic [BLK_W-1:0] rdata
);

  logic [BLK_W-1:0] mem [DEPTH_BLOCKS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/blk_mem_responder.sv
// Memory-side responder for the cache block interface: one request at a time,
// fixed access latency, 4-phase request/ready handshake.
module blk_mem_responder
  import blk_if_pkg::*;
#(
  parameter int DEPTH_BLOCKS = 1024,
  parameter int LATENCY      = 4,
  parameter int IDX_W        = $clog2(DEPTH_BLOCKS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             blk_read,
  input  logic             blk_write,
  input  logic [31:0]      addr,
  input  logic [BLK_W-1:0] block_in,
  output logic [BLK_W-1:0] block_out,
  output logic             blk_ready,
  output logic             busy,
  output logic             req_err,
  output blk_state_e       state_dbg
);

  // Handshake: a request (blk_read/blk_write) is held high until blk_ready is
  // seen; blk_ready then stays high until both request lines are observed low.

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  blk_state_e       state_q, state_d;
  blk_op_e          op_q;
  logic [IDX_W-1:0] idx_q;
  logic [BLK_W-1:0] wdata_q;
  logic [3:0]       cnt_q;
  logic             accept, done;
  logic             mem_we;
  logic [IDX_W-1:0] ram_idx;
  logic [BLK_W-1:0] ram_rdata;
  logic             addr_unused;

  assign addr_unused = ^{addr[31:IDX_W+OFF_BITS], addr[OFF_BITS-1:0]};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (blk_read || blk_write) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          done    = 1'b1;
          state_d = READY;
        end
      end
      READY: begin
        if (!blk_read && !blk_write) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The RAM is addressed from the live address while idle so the block is
  // already in rdata when a LATENCY=1 read completes on the next edge.
  assign ram_idx = (state_q == IDLE) ? addr[IDX_W+OFF_BITS-1:OFF_BITS] : idx_q;
  assign mem_we  = done && (op_q == OP_WR);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      op_q      <= OP_RD;
      idx_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      blk_ready <= 1'b0;
      block_out <= '0;
      req_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= blk_write ? OP_WR : OP_RD;
        idx_q <= addr[IDX_W+OFF_BITS-1:OFF_BITS];
        cnt_q <= LAT_M1;
        if (blk_write) wdata_q <= block_in;
        if (blk_read && blk_write) req_err <= 1'b1;
      end
      if (state_q == ACCESS && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (done) begin
        blk_ready <= 1'b1;
        if (op_q == OP_RD) block_out <= ram_rdata;
      end
      if (state_q == READY && state_d == IDLE) blk_ready <= 1'b0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  blk_mem_array #(
    .DEPTH_BLOCKS(DEPTH_BLOCKS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk  (CLK),
    .we   (mem_we),
    .idx  (ram_idx),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_blk_mem_responder.sv
// Bench for blk_mem_responder: vector table plus hand sequences, reads checked
// against a reference memory through an expected-data queue.
module tb_blk_mem_responder;
  import blk_if_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 1024;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             blk_read, blk_write;
  logic [31:0]      addr;
  logic [BLK_W-1:0] block_in, block_out;
  logic             blk_ready, busy, req_err;
  blk_state_e       state_dbg;

  blk_mem_responder #(.DEPTH_BLOCKS(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .blk_read(blk_read), .blk_write(blk_write),
    .addr(addr), .block_in(block_in), .block_out(block_out),
    .blk_ready(blk_ready), .busy(busy), .req_err(req_err), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [BLK_W-1:0] exp_q[$];
  logic [BLK_W-1:0] model_mem [int];
  logic [BLK_W-1:0] model_out = '0;
  logic             model_err = 1'b0;

  task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Runs one full handshake; hold = extra cycles the request stays high after ready.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [BLK_W-1:0] d, input int hold);
    int idx;
    int k;
    logic [BLK_W-1:0] exp_d;
    idx = int'(a[14:5]);
    @(negedge CLK);
    blk_read = rd; blk_write = wr; addr = a; block_in = d;
    if (wr) begin
      model_mem[idx] = d;
      if (rd) model_err = 1'b1;
    end else begin
      exp_q.push_back(model_mem.exists(idx) ? model_mem[idx] : '0);
    end
    @(posedge CLK); #1;
    chk("accept_busy", 256'(busy), 256'(1));
    chk("accept_state", 256'(state_dbg), 256'(ACCESS));
    block_in = ~d;
    addr = a ^ 32'h0000_0020;
    k = 0;
    while (1) begin
      @(posedge CLK); #1;
      k++;
      if (blk_ready === 1'b1) break;
      if (k > 40) break;
      chk("wait_busy", 256'(busy), 256'(1));
    end
    chk("latency", 256'(k), 256'(LAT));
    if (rd && !wr) begin
      exp_d = exp_q.pop_front();
      model_out = exp_d;
    end
    chk("block_out", block_out, model_out);
    chk("req_err", 256'(req_err), 256'(model_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      chk("hold_ready", 256'(blk_ready), 256'(1));
      chk("hold_state", 256'(state_dbg), 256'(READY));
      chk("hold_out", block_out, model_out);
    end
    blk_read = 1'b0; blk_write = 1'b0;
    @(posedge CLK); #1;
    chk("drop_ready", 256'(blk_ready), 256'(0));
    chk("drop_busy", 256'(busy), 256'(0));
  endtask

  typedef struct {
    logic             rd;
    logic             wr;
    logic [31:0]      a;
    logic [BLK_W-1:0] d;
    int               hold;
    logic             exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    RESET = 1'b1; blk_read = 1'b0; blk_write = 1'b0; addr = '0; block_in = '0;
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0040, {8{32'hDEAD_BEEF}}, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_005C, '0,                 0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_8000, {8{32'h1111_1111}}, 0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0000, '0,                 0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0040, '0,                10, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0100, {8{32'h0BAD_F00D}}, 0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0020, {8{32'hA5A5_A5A5}}, 2, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0020, '0,                 0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 32'hFFFF_0060,
                {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0}, 0, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_0060, '0,                 3, 1'b1};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", 256'(blk_ready), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_err", 256'(req_err), 256'(0));
    chk("rst_out", block_out, '0);
    chk("rst_state", 256'(state_dbg), 256'(IDLE));
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].hold);
      chk($sformatf("vec%0d_err", i), 256'(req_err), 256'(vecs[i].exp_err));
    end

    // Reset two cycles into a write: the write must not land.
    @(negedge CLK);
    blk_write = 1'b1; addr = 32'h0000_0100; block_in = {8{32'hFFFF_FFFF}};
    @(posedge CLK);
    @(posedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b1; blk_write = 1'b0;
    #1;
    chk("mid_rst_state", 256'(state_dbg), 256'(IDLE));
    chk("mid_rst_ready", 256'(blk_ready), 256'(0));
    chk("mid_rst_out", block_out, '0);
    chk("mid_rst_err", 256'(req_err), 256'(0));
    model_out = '0;
    model_err = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    do_txn(1'b1, 1'b0, 32'h0000_0100, '0, 0);

    for (int r = 0; r < 4; r++) begin
      logic [31:0] ra;
      logic [BLK_W-1:0] rd_data;
      ra = {$urandom_range(0, 65535), 16'h0} | (32'($urandom_range(0, DEPTH - 1)) << 5);
      for (int w = 0; w < 8; w++) rd_data[w*32 +: 32] = $urandom;
      do_txn(1'b0, 1'b1, ra, rd_data, $urandom_range(0, 2));
      do_txn(1'b1, 1'b0, {$urandom_range(0, 65535), ra[15:5], 5'($urandom_range(0, 31))},
             '0, $urandom_range(0, 2));
    end

    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
